// File: rtl/comms_processor.sv
// Communications processor between a GPP and the control/data interconnect: TX burst buffer with request/grant, RX notice flag and RX FIFO.
// Optional checksum word at the end of each TX transfer is enabled by defining CP_TX_CHECKSUM_EN.
module comms_processor #(
  parameter int unsigned TX_DEPTH   = 16,
  parameter int unsigned RX_DEPTH   = 16,
  parameter logic [15:0] GRANT_CODE = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] node_id,
  input  logic [15:0] max_node,
  input  logic [31:0] control_rx_packet,
  input  logic        enable_rtr,
  input  logic        gpp_rtr_cp,
  output logic [31:0] control_tx_packet,
  output logic [15:0] data_rx_node_id,
  output logic        data_rx_flag,
  output logic        gpp_trf_cp,
  input  logic [31:0] data_rx_packet,
  input  logic        gpp_rtr_dp,
  output logic [15:0] RAM_rx_data_out,
  input  logic        gpp_trf_dp,
  input  logic [15:0] gpp_tx_data,
  output logic [31:0] data_tx_packet
);

  localparam int unsigned TXS = TX_DEPTH + 1;
  localparam int unsigned CW  = $clog2(TX_DEPTH + 3);
  localparam int unsigned AW  = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int unsigned RCW = $clog2(RX_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, LOAD, REQ, SEND, DONE} tx_state_t;

  tx_state_t     state, state_next;
  logic [15:0]   tx_buf [TXS];
  logic [CW-1:0] tx_cnt, tx_cnt_next;
  logic [CW-1:0] tx_idx, tx_idx_next;
  logic [CW-1:0] pay_n, pay_n_next;
  logic [CW-1:0] last_slot;
  logic [15:0]   dest, dest_next;
  logic [15:0]   last_word;
  logic          cap_en;
  logic [CW-1:0] cap_slot;
  logic [31:0]   control_tx_next, data_tx_next;
  logic          trf_cp_next;
`ifdef CP_TX_CHECKSUM_EN
  logic [15:0]   sum, sum_next;
`endif

  assign last_slot = tx_cnt - CW'(1);
  assign last_word = tx_buf[last_slot];

  // Registered outputs are computed alongside the next state, so each output
  // value becomes visible in the same cycle the FSM enters the matching state.
  always_comb begin
    state_next      = state;
    tx_cnt_next     = tx_cnt;
    tx_idx_next     = tx_idx;
    pay_n_next      = pay_n;
    dest_next       = dest;
    cap_en          = 1'b0;
    cap_slot        = '0;
    control_tx_next = '0;
    data_tx_next    = '0;
    trf_cp_next     = 1'b0;
`ifdef CP_TX_CHECKSUM_EN
    sum_next        = sum;
`endif
    case (state)
      IDLE: begin
        if (gpp_trf_dp) begin
          cap_en      = 1'b1;
          cap_slot    = '0;
          tx_cnt_next = CW'(1);
          state_next  = LOAD;
        end
      end
      LOAD: begin
        if (gpp_trf_dp) begin
          cap_en = 1'b1;
          if (tx_cnt < CW'(TXS)) begin
            cap_slot    = tx_cnt;
            tx_cnt_next = tx_cnt + CW'(1);
          end else begin
            cap_slot = CW'(TX_DEPTH);
          end
        end else if (last_word == 16'h0000 || last_word > max_node ||
                     last_word == node_id) begin
          state_next = IDLE;
        end else if (last_slot == '0) begin
          trf_cp_next = 1'b1;
          state_next  = IDLE;
        end else begin
          dest_next       = last_word;
          pay_n_next      = last_slot;
          control_tx_next = {node_id, last_word};
          state_next      = REQ;
        end
      end
      REQ: begin
        control_tx_next = {node_id, dest};
        if (control_rx_packet == {node_id, GRANT_CODE}) begin
          control_tx_next = '0;
          data_tx_next    = {dest, tx_buf[0]};
          tx_idx_next     = CW'(1);
`ifdef CP_TX_CHECKSUM_EN
          sum_next        = tx_buf[0];
`endif
          state_next      = SEND;
        end
      end
      SEND: begin
        if (tx_idx < pay_n) begin
          data_tx_next = {dest, tx_buf[tx_idx]};
          tx_idx_next  = tx_idx + CW'(1);
`ifdef CP_TX_CHECKSUM_EN
          sum_next     = sum + tx_buf[tx_idx];
        end else if (tx_idx == pay_n) begin
          data_tx_next = {dest, sum};
          tx_idx_next  = tx_idx + CW'(1);
`endif
        end else begin
          control_tx_next = {node_id, 16'h0000};
          trf_cp_next     = 1'b1;
          state_next      = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cap_en) tx_buf[cap_slot] <= gpp_tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      tx_cnt            <= '0;
      tx_idx            <= '0;
      pay_n             <= '0;
      dest              <= '0;
      control_tx_packet <= '0;
      data_tx_packet    <= '0;
      gpp_trf_cp        <= 1'b0;
`ifdef CP_TX_CHECKSUM_EN
      sum               <= '0;
`endif
    end else begin
      state             <= state_next;
      tx_cnt            <= tx_cnt_next;
      tx_idx            <= tx_idx_next;
      pay_n             <= pay_n_next;
      dest              <= dest_next;
      control_tx_packet <= control_tx_next;
      data_tx_packet    <= data_tx_next;
      gpp_trf_cp        <= trf_cp_next;
`ifdef CP_TX_CHECKSUM_EN
      sum               <= sum_next;
`endif
    end
  end

  logic notice;
  assign notice = (control_rx_packet[31:16] == node_id) &&
                  (control_rx_packet[15:0] != 16'h0000) &&
                  (control_rx_packet[15:0] <= max_node);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_rx_flag    <= 1'b0;
      data_rx_node_id <= '0;
    end else if (notice) begin
      data_rx_flag    <= 1'b1;
      data_rx_node_id <= control_rx_packet[15:0];
    end else if (gpp_rtr_cp) begin
      data_rx_flag    <= 1'b0;
    end
  end

  logic [15:0]    rx_mem [RX_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [RCW-1:0] rx_count;
  logic           rx_full, rx_empty, push_req, push_ok, pop_ok;

  assign rx_full  = (rx_count == RCW'(RX_DEPTH));
  assign rx_empty = (rx_count == '0);
  assign push_req = enable_rtr && (data_rx_packet[31:16] == node_id);
  assign pop_ok   = gpp_rtr_dp && !rx_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok  = push_req && (!rx_full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) rx_mem[wr_ptr] <= data_rx_packet[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      rx_count        <= '0;
      RAM_rx_data_out <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == AW'(RX_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr          <= (rd_ptr == AW'(RX_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
        RAM_rx_data_out <= rx_mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   rx_count <= rx_count + RCW'(1);
        2'b01:   rx_count <= rx_count - RCW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

endmodule

// File: tb/tb_comms_processor.sv
// Scoreboard bench for comms_processor: stimulus pushes expected output events, a negedge monitor pops and compares them.
module tb_comms_processor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] node_id, max_node;
  logic [31:0] control_rx_packet, data_rx_packet;
  logic        enable_rtr, gpp_rtr_cp, gpp_rtr_dp, gpp_trf_dp;
  logic [15:0] gpp_tx_data;
  logic [31:0] control_tx_packet, data_tx_packet;
  logic [15:0] data_rx_node_id, RAM_rx_data_out;
  logic        data_rx_flag, gpp_trf_cp;

  comms_processor dut (
    .clk(clk), .rst(rst), .node_id(node_id), .max_node(max_node),
    .control_rx_packet(control_rx_packet), .enable_rtr(enable_rtr),
    .gpp_rtr_cp(gpp_rtr_cp), .control_tx_packet(control_tx_packet),
    .data_rx_node_id(data_rx_node_id), .data_rx_flag(data_rx_flag),
    .gpp_trf_cp(gpp_trf_cp), .data_rx_packet(data_rx_packet),
    .gpp_rtr_dp(gpp_rtr_dp), .RAM_rx_data_out(RAM_rx_data_out),
    .gpp_trf_dp(gpp_trf_dp), .gpp_tx_data(gpp_tx_data),
    .data_tx_packet(data_tx_packet)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic mon_en = 1'b0;

  logic [31:0] exp_ctrl[$], exp_data[$], exp_cp[$], exp_ram[$], exp_flag[$];
  logic [31:0] prev_ctrl, prev_ram, prev_flag;
  logic [15:0] bw[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Each output channel is an event stream; an event with nothing queued is unexpected.
  always @(negedge clk) begin
    if (mon_en) begin
      if (control_tx_packet !== prev_ctrl) begin
        if (exp_ctrl.size() > 0) check("control_tx", control_tx_packet, exp_ctrl.pop_front());
        else check("control_tx_unexpected", control_tx_packet, prev_ctrl);
        prev_ctrl = control_tx_packet;
      end
      if (data_tx_packet !== 32'h0) begin
        if (exp_data.size() > 0) check("data_tx", data_tx_packet, exp_data.pop_front());
        else check("data_tx_unexpected", data_tx_packet, 32'h0);
      end
      if (gpp_trf_cp !== 1'b0) begin
        if (exp_cp.size() > 0) check("trf_cp_ctrl", control_tx_packet, exp_cp.pop_front());
        else check("trf_cp_unexpected", {31'h0, gpp_trf_cp}, 32'h0);
      end
      if ({16'h0, RAM_rx_data_out} !== prev_ram) begin
        if (exp_ram.size() > 0) check("ram_out", {16'h0, RAM_rx_data_out}, exp_ram.pop_front());
        else check("ram_out_unexpected", {16'h0, RAM_rx_data_out}, prev_ram);
        prev_ram = {16'h0, RAM_rx_data_out};
      end
      if ({15'h0, data_rx_flag, data_rx_node_id} !== prev_flag) begin
        if (exp_flag.size() > 0) check("rx_flag", {15'h0, data_rx_flag, data_rx_node_id}, exp_flag.pop_front());
        else check("rx_flag_unexpected", {15'h0, data_rx_flag, data_rx_node_id}, prev_flag);
        prev_flag = {15'h0, data_rx_flag, data_rx_node_id};
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_burst();
    foreach (bw[i]) begin
      gpp_trf_dp  = 1'b1;
      gpp_tx_data = bw[i];
      tick(1);
    end
    gpp_trf_dp  = 1'b0;
    gpp_tx_data = 16'h0;
    bw.delete();
  endtask

  task automatic drain(input string name);
    int left;
    for (int c = 0; c < 200; c++) begin
      left = exp_ctrl.size() + exp_data.size() + exp_cp.size() + exp_ram.size() + exp_flag.size();
      if (left == 0) break;
      tick(1);
    end
    left = exp_ctrl.size() + exp_data.size() + exp_cp.size() + exp_ram.size() + exp_flag.size();
    check(name, left, 32'h0);
    exp_ctrl.delete(); exp_data.delete(); exp_cp.delete(); exp_ram.delete(); exp_flag.delete();
    tick(6);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, control_tx_packet, 32'h0);
    check({tag, "_data"}, data_tx_packet, 32'h0);
    check({tag, "_cp"}, {31'h0, gpp_trf_cp}, 32'h0);
    check({tag, "_flag"}, {31'h0, data_rx_flag}, 32'h0);
    check({tag, "_rxnode"}, {16'h0, data_rx_node_id}, 32'h0);
    check({tag, "_ram"}, {16'h0, RAM_rx_data_out}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; node_id = 16'd1; max_node = 16'd4;
    control_rx_packet = '0; data_rx_packet = '0;
    enable_rtr = 1'b0; gpp_rtr_cp = 1'b0; gpp_rtr_dp = 1'b0;
    gpp_trf_dp = 1'b0; gpp_tx_data = '0;
    tick(2);
    check_all_zero("reset");
    rst = 1'b0;
    tick(3);
    check_all_zero("idle");
    prev_ctrl = 32'h0; prev_ram = 32'h0; prev_flag = 32'h0;
    mon_en = 1'b1;

    // Nominal TX with a non-matching grant held for a few cycles first.
    exp_ctrl.push_back(32'h0001_0004); exp_ctrl.push_back(32'h0);
    exp_ctrl.push_back(32'h0001_0000); exp_ctrl.push_back(32'h0);
    exp_data.push_back(32'h0004_000A); exp_data.push_back(32'h0004_000B);
    exp_data.push_back(32'h0004_000C); exp_data.push_back(32'h0004_000D);
`ifdef CP_TX_CHECKSUM_EN
    exp_data.push_back(32'h0004_002E);
`endif
    exp_cp.push_back(32'h0001_0000);
    bw.push_back(16'h000A); bw.push_back(16'h000B); bw.push_back(16'h000C);
    bw.push_back(16'h000D); bw.push_back(16'h0004);
    send_burst();
    control_rx_packet = 32'h0002_FFFF;
    tick(4);
    control_rx_packet = 32'h0001_FFFF;
    tick(1);
    control_rx_packet = 32'h0;
    drain("tx_nominal_drain");

    // Rejected destinations: above max_node, own node, zero.
    bw.push_back(16'h000A); bw.push_back(16'h0005); send_burst(); tick(4);
    bw.push_back(16'h000A); bw.push_back(16'h0001); send_burst(); tick(4);
    bw.push_back(16'h000A); bw.push_back(16'h0000); send_burst(); tick(4);
    drain("tx_invalid_drain");

    // Destination only, no payload: completion pulse without request.
    exp_cp.push_back(32'h0);
    bw.push_back(16'h0003); send_burst();
    drain("tx_empty_drain");

    // Overlong burst: word 17 overwrites the final slot and becomes dest.
    exp_ctrl.push_back(32'h0001_0002); exp_ctrl.push_back(32'h0);
    exp_ctrl.push_back(32'h0001_0000); exp_ctrl.push_back(32'h0);
    for (int i = 0; i < 16; i++) exp_data.push_back(32'h0002_0100 + i);
`ifdef CP_TX_CHECKSUM_EN
    exp_data.push_back(32'h0002_1078);
`endif
    exp_cp.push_back(32'h0001_0000);
    for (int i = 0; i < 17; i++) bw.push_back(16'h0100 + 16'(i));
    bw.push_back(16'h0002);
    send_burst();
    tick(2);
    control_rx_packet = 32'h0001_FFFF;
    tick(1);
    control_rx_packet = 32'h0;
    drain("tx_overflow_drain");

    // RX notice, data capture, gating and pops.
    exp_flag.push_back(32'h0001_0003);
    exp_ram.push_back(32'h1234); exp_ram.push_back(32'h5678);
    control_rx_packet = 32'h0001_0003; tick(1);
    control_rx_packet = 32'h0001_0005; tick(1);
    control_rx_packet = 32'h0001_0000; tick(1);
    control_rx_packet = 32'h0;
    enable_rtr = 1'b1;
    data_rx_packet = 32'h0001_1234; tick(1);
    data_rx_packet = 32'h0001_5678; tick(1);
    data_rx_packet = 32'h0002_1234; tick(1);
    enable_rtr = 1'b0;
    data_rx_packet = 32'h0001_9999; tick(1);
    data_rx_packet = 32'h0;
    for (int i = 0; i < 3; i++) begin
      gpp_rtr_dp = 1'b1; tick(1);
      gpp_rtr_dp = 1'b0; tick(2);
    end
    drain("rx_data_drain");

    exp_flag.push_back(32'h0000_0003);
    exp_flag.push_back(32'h0001_0002);
    exp_flag.push_back(32'h0000_0002);
    gpp_rtr_cp = 1'b1; tick(1);
    gpp_rtr_cp = 1'b0; tick(2);
    control_rx_packet = 32'h0001_0002; gpp_rtr_cp = 1'b1; tick(1);
    control_rx_packet = 32'h0; tick(1);
    gpp_rtr_cp = 1'b0; tick(1);
    drain("rx_flag_drain");

    // Fill the FIFO, overflow drop, then push and pop together while full.
    for (int i = 0; i < 16; i++) exp_ram.push_back(32'h2000 + i);
    exp_ram.push_back(32'h3000);
    enable_rtr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_rx_packet = 32'h0001_2000 + i; tick(1);
    end
    data_rx_packet = 32'h0001_2010; tick(1);
    data_rx_packet = 32'h0001_3000; gpp_rtr_dp = 1'b1; tick(1);
    data_rx_packet = 32'h0;
    tick(17);
    gpp_rtr_dp = 1'b0; enable_rtr = 1'b0;
    drain("rx_full_drain");

    // Reset while requesting: everything clears, no release or pulse follows.
    exp_ctrl.push_back(32'h0001_0004); exp_ctrl.push_back(32'h0);
    exp_ram.push_back(32'h0);
    exp_flag.push_back(32'h0);
    bw.push_back(16'h000A); bw.push_back(16'h000B); bw.push_back(16'h0004);
    send_burst();
    tick(3);
    rst = 1'b1; tick(2);
    rst = 1'b0; tick(4);
    control_rx_packet = 32'h0001_FFFF; tick(1);
    control_rx_packet = 32'h0; tick(4);
    drain("reset_abort_drain");
    check_all_zero("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
